axi_slave_mem: RTL and testbench

AXI4 slave memory that sits directly downstream of the team's AXI4 burst masters and consumes their transactions. It terminates AW/W/B and AR/R into an internal dual-port word RAM and is used as the bench target and the on-chip scratchpad. Write and read paths are independent FSMs, each allowing one outstanding burst. AxLOCK/AxCACHE/AxPROT/AxQOS are not ported and stay unconnected at integration.

---
 rtl/axi_slave_mem.sv | 277 +++++++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI4 slave backed by a dual-port word RAM.
// Serves as the bench target and the on-chip scratchpad.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   S_AXI_AW*         - write address channel (ADDR, LEN, SIZE, BURST, VALID/READY)
//   S_AXI_W*          - write data channel (DATA, STRB, LAST, VALID/READY)
//   S_AXI_B*          - write response channel (RESP, VALID/READY)
//   S_AXI_AR*         - read address channel (ADDR, LEN, SIZE, BURST, VALID/READY)
//   S_AXI_R*          - read data channel (DATA, RESP, LAST, VALID/READY)
// Write and read paths are independent FSMs, each with one burst in flight.
// FIXED and INCR bursts are supported. A bad request or a WLAST mismatch
// yields SLVERR, suppresses further RAM writes and forces read data to zero.
module axi_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                S_AXI_AWLEN,
  input  logic [2:0]                S_AXI_AWSIZE,
  input  logic [1:0]                S_AXI_AWBURST,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WLAST,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                S_AXI_ARLEN,
  input  logic [2:0]                S_AXI_ARSIZE,
  input  logic [1:0]                S_AXI_ARBURST,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SIZE_LOG2  = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_e;

  // Request check at address accept: burst type, beat size, start and end word range.
  function automatic logic req_err(input logic [ADDR_WIDTH-1:0] addr,
                                   input logic [7:0]            len,
                                   input logic [2:0]            size,
                                   input logic [1:0]            burst);
    logic [ADDR_WIDTH:0] first_w;
    logic [ADDR_WIDTH:0] last_w;
    first_w = {1'b0, addr >> SIZE_LOG2};
    last_w  = first_w + (ADDR_WIDTH+1)'(len);
    return ((burst != BURST_FIXED) && (burst != BURST_INCR)) ||
           (size != 3'(SIZE_LOG2)) ||
           (first_w >= (ADDR_WIDTH+1)'(DEPTH)) ||
           ((burst == BURST_INCR) && (last_w >= (ADDR_WIDTH+1)'(DEPTH)));
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write path ----------------
  w_state_e               w_state_q, w_state_d;
  logic [IDX_WIDTH-1:0]   w_idx_q, w_idx_d;
  logic [7:0]             w_len_q, w_len_d;
  logic [7:0]             w_beat_q, w_beat_d;
  logic                   w_incr_q, w_incr_d;
  logic                   w_err_q, w_err_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   aw_hs_c, w_hs_c, b_hs_c, w_last_c, mem_we_c;

  assign aw_hs_c  = S_AXI_AWVALID && awready_q;
  assign w_hs_c   = S_AXI_WVALID && wready_q;
  assign b_hs_c   = S_AXI_BREADY && bvalid_q;
  assign w_last_c = (w_beat_q == w_len_q);
  // An error already flagged blocks this beat; a WLAST mismatch blocks the following beats.
  assign mem_we_c = (w_state_q == W_DATA) && w_hs_c && !w_err_q;

  // Write state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_incr_q  <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_incr_q  <= w_incr_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Write next-state and burst tracking.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_incr_d  = w_incr_q;
    w_err_d   = w_err_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_c) begin
          w_state_d = W_DATA;
          w_idx_d   = IDX_WIDTH'(S_AXI_AWADDR >> SIZE_LOG2);
          w_len_d   = S_AXI_AWLEN;
          w_beat_d  = 8'd0;
          w_incr_d  = (S_AXI_AWBURST == BURST_INCR);
          w_err_d   = req_err(S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
        end
      end
      W_DATA: begin
        if (w_hs_c) begin
          if (w_incr_q) w_idx_d = w_idx_q + IDX_WIDTH'(1);
          if (S_AXI_WLAST != w_last_c) w_err_d = 1'b1;
          // Beat LEN ends the burst whatever WLAST says; counter never wraps.
          if (w_last_c) w_state_d = W_RESP;
          else          w_beat_d  = w_beat_q + 8'd1;
        end
      end
      W_RESP: begin
        if (b_hs_c) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel outputs, registered from the next state.
  always_comb begin
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = (bvalid_d && w_err_d) ? RESP_SLVERR : RESP_OKAY;
  end

  // Byte-enabled RAM write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (S_AXI_WSTRB[b]) mem[w_idx_q][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e               r_state_q, r_state_d;
  logic [IDX_WIDTH-1:0]   r_idx_q, r_idx_d;
  logic [7:0]             r_len_q, r_len_d;
  logic [7:0]             r_beat_q, r_beat_d;
  logic                   r_incr_q, r_incr_d;
  logic                   r_err_q, r_err_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rlast_q, rlast_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   ar_hs_c, r_hs_c, r_last_c;

  assign ar_hs_c  = S_AXI_ARVALID && arready_q;
  assign r_hs_c   = S_AXI_RREADY && rvalid_q;
  assign r_last_c = (r_beat_q == r_len_q);

  // Read state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_incr_q  <= 1'b0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_incr_q  <= r_incr_d;
      r_err_q   <= r_err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Read next-state and burst tracking.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_incr_d  = r_incr_q;
    r_err_d   = r_err_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_c) begin
          r_state_d = R_FETCH;
          r_idx_d   = IDX_WIDTH'(S_AXI_ARADDR >> SIZE_LOG2);
          r_len_d   = S_AXI_ARLEN;
          r_beat_d  = 8'd0;
          r_incr_d  = (S_AXI_ARBURST == BURST_INCR);
          r_err_d   = req_err(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
        end
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: begin
        if (r_hs_c) begin
          if (r_last_c) begin
            r_state_d = R_IDLE;
          end else begin
            r_state_d = R_FETCH;
            r_beat_d  = r_beat_q + 8'd1;
            if (r_incr_q) r_idx_d = r_idx_q + IDX_WIDTH'(1);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel outputs; RDATA is loaded once per beat in R_FETCH and then held.
  always_comb begin
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rlast_d   = rvalid_d && (r_beat_d == r_len_d);
    rresp_d   = (rvalid_d && r_err_d) ? RESP_SLVERR : RESP_OKAY;
    rdata_d   = rdata_q;
    if (r_state_q == R_FETCH) rdata_d = r_err_q ? '0 : mem[r_idx_q];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: directed table of AXI bursts with hand-computed responses
// and data, plus hand-written reset-abort and concurrent read/write sequences.
module tb_axi_slave_mem;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 1024;
  localparam int          TMO   = 50;

  logic            clk, rst;
  logic [AW-1:0]   aw_addr;  logic [7:0] aw_len; logic [2:0] aw_size; logic [1:0] aw_burst;
  logic            aw_valid, aw_ready;
  logic [DW-1:0]   w_data;   logic [DW/8-1:0] w_strb; logic w_last, w_valid, w_ready;
  logic [1:0]      b_resp;   logic b_valid, b_ready;
  logic [AW-1:0]   ar_addr;  logic [7:0] ar_len; logic [2:0] ar_size; logic [1:0] ar_burst;
  logic            ar_valid, ar_ready;
  logic [DW-1:0]   r_data;   logic [1:0] r_resp; logic r_last, r_valid, r_ready;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  axi_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(aw_addr), .S_AXI_AWLEN(aw_len), .S_AXI_AWSIZE(aw_size),
    .S_AXI_AWBURST(aw_burst), .S_AXI_AWVALID(aw_valid), .S_AXI_AWREADY(aw_ready),
    .S_AXI_WDATA(w_data), .S_AXI_WSTRB(w_strb), .S_AXI_WLAST(w_last),
    .S_AXI_WVALID(w_valid), .S_AXI_WREADY(w_ready),
    .S_AXI_BRESP(b_resp), .S_AXI_BVALID(b_valid), .S_AXI_BREADY(b_ready),
    .S_AXI_ARADDR(ar_addr), .S_AXI_ARLEN(ar_len), .S_AXI_ARSIZE(ar_size),
    .S_AXI_ARBURST(ar_burst), .S_AXI_ARVALID(ar_valid), .S_AXI_ARREADY(ar_ready),
    .S_AXI_RDATA(r_data), .S_AXI_RRESP(r_resp), .S_AXI_RLAST(r_last),
    .S_AXI_RVALID(r_valid), .S_AXI_RREADY(r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [63:0] d [4];   // write data, or expected read data, for beat i%4
    logic [7:0]  strb;
    int          wlast_at;
    int          bdelay;
    logic [1:0]  resp;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [7:0] l,
                              input logic [1:0] b, input logic [2:0] s,
                              input logic [63:0] d0, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] d3,
                              input logic [7:0] st, input int wl, input int bd,
                              input logic [1:0] r);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = l; v.burst = b; v.size = s;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.strb = st; v.wlast_at = (wl < 0) ? int'(l) : wl; v.bdelay = bd; v.resp = r;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input vec_t v, input string tag);
    int n;
    int acc;
    @(negedge clk);
    aw_addr = v.addr; aw_len = v.len; aw_size = v.size; aw_burst = v.burst; aw_valid = 1'b1;
    n = 0;
    while (!aw_ready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check({tag, " aw_timeout"}, 64'(1), 64'(0));
    @(negedge clk);
    aw_valid = 1'b0;
    acc = 0;
    for (int i = 0; i <= int'(v.len); i++) begin
      w_data = v.d[i % 4]; w_strb = v.strb; w_last = (i == v.wlast_at); w_valid = 1'b1;
      n = 0;
      while (!w_ready && n < TMO) begin @(negedge clk); n++; end
      if (w_ready) acc++;
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
    check({tag, " beats_accepted"}, 64'(acc), 64'(int'(v.len) + 1));
    n = 0;
    while (!b_valid && n < TMO) begin @(negedge clk); n++; end
    for (int k = 0; k < v.bdelay; k++) begin
      check({tag, " bvalid_held"}, 64'(b_valid), 64'(1));
      check({tag, " bresp_held"}, 64'(b_resp), 64'(v.resp));
      check({tag, " awready_blocked"}, 64'(aw_ready), 64'(0));
      @(negedge clk);
    end
    check({tag, " bvalid"}, 64'(b_valid), 64'(1));
    check({tag, " bresp"}, 64'(b_resp), 64'(v.resp));
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    check({tag, " bvalid_after"}, 64'(b_valid), 64'(0));
    check({tag, " awready_after"}, 64'(aw_ready), 64'(1));
  endtask

  task automatic do_read(input vec_t v, input string tag);
    int n;
    int n0;
    @(negedge clk);
    ar_addr = v.addr; ar_len = v.len; ar_size = v.size; ar_burst = v.burst; ar_valid = 1'b1;
    r_ready = 1'b1;
    n = 0;
    while (!ar_ready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) check({tag, " ar_timeout"}, 64'(1), 64'(0));
    n0 = cyc;
    @(negedge clk);
    ar_valid = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      n = 0;
      while (!r_valid && n < TMO) begin @(negedge clk); n++; end
      if (i == 0) check({tag, " first_rvalid_latency"}, 64'(cyc - n0), 64'(2));
      check($sformatf("%s rdata[%0d]", tag, i), r_data, v.d[i % 4]);
      check($sformatf("%s rresp[%0d]", tag, i), 64'(r_resp), 64'(v.resp));
      check($sformatf("%s rlast[%0d]", tag, i), 64'(r_last), 64'(i == int'(v.len)));
      @(negedge clk);
    end
    r_ready = 1'b0;
    check({tag, " rvalid_after"}, 64'(r_valid), 64'(0));
  endtask

  localparam logic [1:0] FX = 2'b00, IN = 2'b01, WR = 2'b10, OK = 2'b00, SE = 2'b10;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111, D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_3333, D4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] P5 = 64'h5A5A_5A5A_5A5A_5A5A, CF = 64'hCAFE_F00D_0123_4567;

  initial begin
    vec_t v;
    rst = 1'b1;
    aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
    ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b0; r_ready = 1'b0;

    //      wr  addr        len    brst sz d0    d1    d2    d3    strb   wl  bd resp
    tbl.push_back(mk(1, 32'h100,  8'd3,   IN, 3, D1,   D2,   D3,   D4,   8'hFF, -1, 0, OK));
    tbl.push_back(mk(0, 32'h100,  8'd3,   IN, 3, D1,   D2,   D3,   D4,   8'h00, -1, 0, OK));
    tbl.push_back(mk(1, 32'h0,    8'd0,   IN, 3, ONES, 0,    0,    0,    8'hFF, -1, 0, OK));
    tbl.push_back(mk(1, 32'h0,    8'd0,   IN, 3, 0,    0,    0,    0,    8'h0F, -1, 0, OK));
    tbl.push_back(mk(0, 32'h0,    8'd0,   IN, 3, 64'hFFFF_FFFF_0000_0000, 0, 0, 0, 8'h00, -1, 0, OK));
    tbl.push_back(mk(1, 32'h1FF8, 8'd0,   IN, 3, P5,   0,    0,    0,    8'hFF, -1, 0, OK));
    tbl.push_back(mk(1, 32'h1FF8, 8'd1,   IN, 3, D1,   D2,   0,    0,    8'hFF, -1, 0, SE));
    tbl.push_back(mk(0, 32'h1FF8, 8'd0,   IN, 3, P5,   0,    0,    0,    8'h00, -1, 0, OK));
    tbl.push_back(mk(0, 32'h2000, 8'd0,   IN, 3, 0,    0,    0,    0,    8'h00, -1, 0, SE));
    tbl.push_back(mk(1, 32'h200,  8'd3,   IN, 3, D1,   D2,   D3,   D4,   8'hFF,  1, 5, SE));
    tbl.push_back(mk(0, 32'h200,  8'd0,   IN, 3, D1,   0,    0,    0,    8'h00, -1, 0, OK));
    tbl.push_back(mk(1, 32'h300,  8'd0,   IN, 3, CF,   0,    0,    0,    8'hFF, -1, 0, OK));
    tbl.push_back(mk(1, 32'h300,  8'd0,   WR, 3, D1,   0,    0,    0,    8'hFF, -1, 0, SE));
    tbl.push_back(mk(1, 32'h300,  8'd0,   IN, 2, D2,   0,    0,    0,    8'hFF, -1, 0, SE));
    tbl.push_back(mk(0, 32'h300,  8'd0,   IN, 3, CF,   0,    0,    0,    8'h00, -1, 0, OK));
    tbl.push_back(mk(0, 32'h100,  8'd1,   2'b11, 3, 0, 0,    0,    0,    8'h00, -1, 0, SE));
    tbl.push_back(mk(0, 32'h100,  8'd0,   FX, 2, 0,    0,    0,    0,    8'h00, -1, 0, SE));
    tbl.push_back(mk(0, 32'h100,  8'd1,   FX, 3, D1,   D1,   0,    0,    8'h00, -1, 0, OK));
    tbl.push_back(mk(1, 32'h1800, 8'd255, IN, 3, D1,   D2,   D3,   D4,   8'hFF, -1, 0, OK));
    tbl.push_back(mk(0, 32'h1800, 8'd255, IN, 3, D1,   D2,   D3,   D4,   8'h00, -1, 0, OK));
    tbl.push_back(mk(1, 32'h1808, 8'd255, IN, 3, D1,   D2,   D3,   D4,   8'hFF, -1, 0, SE));

    // Outputs held at zero during reset, readies rise one cycle after release.
    repeat (2) @(negedge clk);
    check("reset_ctrl_outs", 64'({aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_last, r_resp}), 64'(0));
    check("reset_rdata", r_data, 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("awready_after_reset", 64'(aw_ready), 64'(1));
    check("arready_after_reset", 64'(ar_ready), 64'(1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) do_write(tbl[i], $sformatf("row%0d_wr", i));
      else           do_read(tbl[i], $sformatf("row%0d_rd", i));
    end

    // FIXED write concurrent with an INCR read of a different region.
    do_write(mk(1, 32'h80, 8'd3, IN, 3, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 8'hFF, -1, 0, OK), "preload80");
    fork
      do_write(mk(1, 32'h40, 8'd2, FX, 3, 64'hA, 64'hB, 64'hC, 0, 8'hFF, -1, 0, OK), "fixed40");
      do_read(mk(0, 32'h80, 8'd3, IN, 3, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 8'h00, -1, 0, OK), "conc_rd80");
    join
    do_read(mk(0, 32'h40, 8'd0, IN, 3, 64'hC, 0, 0, 0, 8'h00, -1, 0, OK), "fixed40_rd");

    // Reset during beat 2 of a LEN=3 write aborts it with no response.
    @(negedge clk);
    aw_addr = 32'h400; aw_len = 8'd3; aw_size = 3'd3; aw_burst = IN; aw_valid = 1'b1;
    for (int n = 0; n < TMO && !aw_ready; n++) @(negedge clk);
    @(negedge clk);
    aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w_data = 64'(i + 7); w_strb = 8'hFF; w_valid = 1'b1;
      for (int n = 0; n < TMO && !w_ready; n++) @(negedge clk);
      @(negedge clk);
    end
    check("midburst_wready_before_rst", 64'(w_ready), 64'(1));
    w_data = 64'h9; rst = 1'b1;
    #1;
    check("rst_wready_drop", 64'(w_ready), 64'(0));
    check("rst_bvalid_low", 64'(b_valid), 64'(0));
    check("rst_awready_low", 64'(aw_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0; w_valid = 1'b0; b_ready = 1'b1;
    @(negedge clk);
    check("awready_one_cycle_after_release", 64'(aw_ready), 64'(1));
    begin
      int seen;
      seen = 0;
      repeat (8) begin
        if (b_valid) seen++;
        @(negedge clk);
      end
      check("no_bvalid_after_abort", 64'(seen), 64'(0));
    end
    b_ready = 1'b0;
    // RAM contents survive reset.
    v = mk(0, 32'h100, 8'd0, IN, 3, D1, 0, 0, 0, 8'h00, -1, 0, OK);
    do_read(v, "post_reset_rd100");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
